// File: rtl/timer_pkg.sv
// Shared timer definitions: FSM state encoding and a counter-width helper.
// Reused by the up counter and the countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } timer_state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides advancing cycles by PRESCALE; tick is high on the last advancing cycle of each period.
// Combinational tick, registered phase counter; clr wins over adv.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic adv,
  output logic tick
);

  localparam int unsigned   PW   = cnt_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  assign tick = adv && (phase == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (adv) begin
      phase <= tick ? '0 : phase + PW'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with pause/resume, one-cycle done pulse and optional auto-reload.
// Edge priority is load > pause > start; count/done are registered, busy/expired decode the state register.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             expired
);

  timer_state_t     state;
  logic [WIDTH-1:0] reload_val;
  logic             tick;
  logic             go;
  logic             pre_clr;
  logic             pre_adv;

  assign go      = (state == IDLE) && start && !pause && (count != '0);
  assign pre_clr = load || go;
  // The prescaler must not move on an edge whose tick would be discarded.
  assign pre_adv = (state == RUN) && enable && !load && !pause;

  timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (pre_clr),
    .adv   (pre_adv),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      reload_val <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state      <= IDLE;
        count      <= load_value;
        reload_val <= load_value;
      end else begin
        case (state)
          IDLE: begin
            if (go) state <= RUN;
          end
          RUN: begin
            if (pause) begin
              state <= PAUSE;
            end else if (tick) begin
              if (count == WIDTH'(1)) begin
                done <= 1'b1;
                if (auto_reload) begin
                  count <= reload_val;
                end else begin
                  count <= '0;
                  state <= DONE;
                end
              end else begin
                count <= count - WIDTH'(1);
              end
            end
          end
          PAUSE: begin
            if (start && !pause) state <= RUN;
          end
          default: begin
            count <= '0;
          end
        endcase
      end
    end
  end

  assign busy    = (state == RUN) || (state == PAUSE);
  assign expired = (state == DONE);

endmodule
